// File: rtl/ex_stage_fwd_pkg.sv
// Shared constants and helpers for the execute stage: opcodes, condition codes, CCR bit layout.
package ex_stage_fwd_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] COND_ALWAYS     = 2'b00;
    localparam logic [1:0] COND_ZERO       = 2'b01;
    localparam logic [1:0] COND_CARRY      = 2'b10;
    localparam logic [1:0] COND_ALWAYS_ALT = 2'b11;

    // CCR layout is {zero, carry}
    localparam int unsigned ZF = 1;
    localparam int unsigned CF = 0;

    // True when the condition depends on the CCR at all
    function automatic logic cond_uses_flags(input logic [1:0] cond);
        return (cond == COND_ZERO) || (cond == COND_CARRY);
    endfunction

    // Evaluate an execution condition against a CCR value
    function automatic logic cond_pass(input logic [1:0] cond, input logic [1:0] flags);
        logic pass;
        case (cond)
            COND_CARRY:                   pass = flags[CF];
            COND_ZERO:                    pass = flags[ZF];
            COND_ALWAYS, COND_ALWAYS_ALT: pass = 1'b1;
            default:                      pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/ex_stage_fwd_if.sv
// Issue, bypass and result bus between register-read, execute and memory stages.
interface ex_stage_fwd_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REG_BITS = 3,
    parameter int unsigned NUM_FWD  = 3
);
    // Issue side
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  in_op;
    logic [1:0]                  in_cond;
    logic                        in_flag_we;
    logic [REG_BITS-1:0]         in_src_a;
    logic [REG_BITS-1:0]         in_src_b;
    logic                        in_use_a;
    logic                        in_use_b;
    logic [WIDTH-1:0]            in_rf_a;
    logic [WIDTH-1:0]            in_rf_b;
    logic [WIDTH-1:0]            in_imm;
    logic                        in_imm_sel;
    logic [REG_BITS-1:0]         in_dest;
    logic                        in_dest_we;

    // Bypass network and late CCR traffic from older instructions
    logic [NUM_FWD-1:0]          fwd_valid;
    logic [NUM_FWD*REG_BITS-1:0] fwd_reg;
    logic [NUM_FWD*WIDTH-1:0]    fwd_data;
    logic [NUM_FWD-1:0]          fwd_pending;
    logic                        flag_pending;
    logic                        ccr_wr_en;
    logic [1:0]                  ccr_wr_val;

    // Result side
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_result;
    logic [REG_BITS-1:0]         out_dest;
    logic                        out_wr_en;
    logic [1:0]                  out_flags;

    modport master (
        output in_valid, in_op, in_cond, in_flag_we, in_src_a, in_src_b, in_use_a, in_use_b,
               in_rf_a, in_rf_b, in_imm, in_imm_sel, in_dest, in_dest_we,
               fwd_valid, fwd_reg, fwd_data, fwd_pending, flag_pending, ccr_wr_en, ccr_wr_val,
               out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_wr_en, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_cond, in_flag_we, in_src_a, in_src_b, in_use_a, in_use_b,
               in_rf_a, in_rf_b, in_imm, in_imm_sel, in_dest, in_dest_we,
               fwd_valid, fwd_reg, fwd_data, fwd_pending, flag_pending, ccr_wr_en, ccr_wr_val,
               out_ready,
        output in_ready, out_valid, out_result, out_dest, out_wr_en, out_flags
    );

endinterface

// File: rtl/ex_stage_fwd_fwd_select.sv
// Operand forwarding mux: own result register, then youngest matching bypass, then register file.
module ex_stage_fwd_fwd_select #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REG_BITS = 3,
    parameter int unsigned NUM_FWD  = 3
) (
    input  logic [REG_BITS-1:0]         src,
    input  logic                        own_valid,
    input  logic [REG_BITS-1:0]         own_dest,
    input  logic [WIDTH-1:0]            own_data,
    input  logic [WIDTH-1:0]            rf,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD*REG_BITS-1:0] fwd_reg,
    input  logic [NUM_FWD*WIDTH-1:0]    fwd_data,
    input  logic [NUM_FWD-1:0]          fwd_pending,
    output logic [WIDTH-1:0]            value,
    output logic                        pending
);

    logic found;

    // Priority select; the own register is never pending
    always_comb begin
        value   = rf;
        pending = 1'b0;
        found   = 1'b0;
        if (own_valid && (own_dest == src)) begin
            value = own_data;
            found = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!found && fwd_valid[i] && (fwd_reg[i*REG_BITS +: REG_BITS] == src)) begin
                value   = fwd_data[i*WIDTH +: WIDTH];
                pending = fwd_pending[i];
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_stage_fwd.sv
// Execute stage: forwarded operands, ALU, conditional execution, CCR ownership, hazard stall.
module ex_stage_fwd
    import ex_stage_fwd_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REG_BITS = 3,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    ex_stage_fwd_if.slave    bus,
    output logic [1:0]       ccr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic                out_valid_q;
    logic [WIDTH-1:0]    out_result_q;
    logic [REG_BITS-1:0] out_dest_q;
    logic                out_wr_en_q;
    logic [1:0]          out_flags_q;
    logic [1:0]          ccr_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic [WIDTH-1:0]    fwd_a;
    logic [WIDTH-1:0]    fwd_b;
    logic                pend_a;
    logic                pend_b;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_carry;
    logic [1:0]          alu_flags;
    logic [1:0]          ccr_eff;
    logic                pass;
    logic                hazard;
    logic                fire;
    logic                own_valid;

    assign own_valid = out_valid_q && out_wr_en_q;

    ex_stage_fwd_fwd_select #(
        .WIDTH    (WIDTH),
        .REG_BITS (REG_BITS),
        .NUM_FWD  (NUM_FWD)
    ) u_sel_a (
        .src         (bus.in_src_a),
        .own_valid   (own_valid),
        .own_dest    (out_dest_q),
        .own_data    (out_result_q),
        .rf          (bus.in_rf_a),
        .fwd_valid   (bus.fwd_valid),
        .fwd_reg     (bus.fwd_reg),
        .fwd_data    (bus.fwd_data),
        .fwd_pending (bus.fwd_pending),
        .value       (fwd_a),
        .pending     (pend_a)
    );

    ex_stage_fwd_fwd_select #(
        .WIDTH    (WIDTH),
        .REG_BITS (REG_BITS),
        .NUM_FWD  (NUM_FWD)
    ) u_sel_b (
        .src         (bus.in_src_b),
        .own_valid   (own_valid),
        .own_dest    (out_dest_q),
        .own_data    (out_result_q),
        .rf          (bus.in_rf_b),
        .fwd_valid   (bus.fwd_valid),
        .fwd_reg     (bus.fwd_reg),
        .fwd_data    (bus.fwd_data),
        .fwd_pending (bus.fwd_pending),
        .value       (fwd_b),
        .pending     (pend_b)
    );

    // Operand selection, ALU, condition check and hazard detection
    always_comb begin
        op_a = fwd_a;
        op_b = bus.in_imm_sel ? bus.in_imm : fwd_b;

        sum        = {1'b0, op_a} + {1'b0, op_b};
        alu_result = op_b;
        alu_carry  = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_carry  = sum[WIDTH];
            end
            OP_NAND:          alu_result = ~(op_a & op_b);
            OP_PASS, OP_RSVD: alu_result = op_b;
            default:          alu_result = op_b;
        endcase
        alu_flags     = 2'b00;
        alu_flags[ZF] = (alu_result == '0);
        alu_flags[CF] = alu_carry;

        // A same-cycle late write from an older instruction is visible to the condition
        ccr_eff = bus.ccr_wr_en ? bus.ccr_wr_val : ccr_q;
        pass    = cond_pass(bus.in_cond, ccr_eff);

        // An immediate B operand never waits on the bypass network
        hazard = (bus.in_use_a && pend_a)
              || (bus.in_use_b && !bus.in_imm_sel && pend_b)
              || (cond_uses_flags(bus.in_cond) && bus.flag_pending);

        bus.in_ready = reset && (!out_valid_q || bus.out_ready) && !hazard;
        fire         = bus.in_valid && bus.in_ready && !flush;
    end

    // Output register: load on fire, hold under backpressure, drain otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            out_wr_en_q  <= 1'b0;
            out_flags_q  <= 2'b00;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_result;
            out_dest_q   <= bus.in_dest;
            out_wr_en_q  <= bus.in_dest_we && pass;
            out_flags_q  <= alu_flags;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // CCR: the executing (younger) instruction wins over the late writeback update
    always_ff @(posedge clk) begin
        if (!reset) begin
            ccr_q <= 2'b00;
        end else if (fire && pass && bus.in_flag_we) begin
            ccr_q <= alu_flags;
        end else if (bus.ccr_wr_en) begin
            ccr_q <= bus.ccr_wr_val;
        end
    end

    // Saturating count of cycles an offered instruction was held by a hazard
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (bus.in_valid && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_dest   = out_dest_q;
    assign bus.out_wr_en  = out_wr_en_q;
    assign bus.out_flags  = out_flags_q;
    assign ccr            = ccr_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Scoreboard bench for ex_stage_fwd: stimulus pushes expected results, a monitor pops and compares.
module tb_ex_stage_fwd;
    import ex_stage_fwd_pkg::*;

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  dest;
        logic        wr_en;
        logic [1:0]  flags;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  ccr;
    logic [15:0] stall_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    ex_stage_fwd_if #(.WIDTH(16), .REG_BITS(3), .NUM_FWD(3)) bus ();

    ex_stage_fwd #(
        .WIDTH    (16),
        .REG_BITS (3),
        .NUM_FWD  (3),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .ccr       (ccr),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [2:0] d, input logic w,
                                input logic [1:0] f);
        exp_t e;
        e.result = r;
        e.dest   = d;
        e.wr_en  = w;
        e.flags  = f;
        return e;
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [1:0] cond, input logic flag_we,
                             input logic [2:0] sa, input logic [2:0] sb_, input logic ua,
                             input logic ub, input logic [15:0] rfa, input logic [15:0] rfb,
                             input logic [15:0] imm, input logic imm_sel, input logic [2:0] dest,
                             input logic dest_we);
        bus.in_op      = op;
        bus.in_cond    = cond;
        bus.in_flag_we = flag_we;
        bus.in_src_a   = sa;
        bus.in_src_b   = sb_;
        bus.in_use_a   = ua;
        bus.in_use_b   = ub;
        bus.in_rf_a    = rfa;
        bus.in_rf_b    = rfb;
        bus.in_imm     = imm;
        bus.in_imm_sel = imm_sel;
        bus.in_dest    = dest;
        bus.in_dest_we = dest_we;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic [2:0] r,
                           input logic [15:0] d, input logic p);
        bus.fwd_valid[i]          = v;
        bus.fwd_reg[i*3 +: 3]     = r;
        bus.fwd_data[i*16 +: 16]  = d;
        bus.fwd_pending[i]        = p;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer the staged instruction, wait (bounded) for acceptance, record its expected result
    task automatic issue(input exp_t e, input string name);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        if (ok) sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every result handed downstream must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {16'd0, bus.out_result}, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", {16'd0, bus.out_result}, {16'd0, e.result});
                    chk("out_dest", {29'd0, bus.out_dest}, {29'd0, e.dest});
                    chk("out_wr_en", {31'd0, bus.out_wr_en}, {31'd0, e.wr_en});
                    chk("out_flags", {30'd0, bus.out_flags}, {30'd0, e.flags});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.fwd_valid    = '0;
        bus.fwd_reg      = '0;
        bus.fwd_data     = '0;
        bus.fwd_pending  = '0;
        bus.flag_pending = 1'b0;
        bus.ccr_wr_en    = 1'b0;
        bus.ccr_wr_val   = 2'b00;
        set_instr(OP_ADD, COND_ALWAYS, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0,
                  3'd0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_ccr", ccr, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        next_cycle();
        reset = 1'b1;

        // Back-to-back dependent ADD through the own result register
        set_instr(OP_ADD, COND_ALWAYS, 1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 16'd5, 16'd7, 16'd0, 1'b0,
                  3'd1, 1'b1);
        issue(mk(16'd12, 3'd1, 1'b1, 2'b00), "add_5_7");
        set_instr(OP_ADD, COND_ALWAYS, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0,
                  3'd2, 1'b1);
        issue(mk(16'd24, 3'd2, 1'b1, 2'b00), "add_r1_r1");
        @(negedge clk);
        chk("ccr_after_add", ccr, 2'b00);
        next_cycle();

        // Carry and zero generation, then carry-conditional ADD, then NAND
        set_instr(OP_ADD, COND_ALWAYS, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'd0,
                  1'b0, 3'd3, 1'b1);
        issue(mk(16'h0000, 3'd3, 1'b1, 2'b11), "add_wrap");
        @(negedge clk);
        chk("ccr_after_wrap", ccr, 2'b11);
        next_cycle();
        set_instr(OP_ADD, COND_CARRY, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'd1, 16'd2, 16'd0, 1'b0,
                  3'd4, 1'b1);
        issue(mk(16'd3, 3'd4, 1'b1, 2'b00), "adc_taken");
        @(negedge clk);
        chk("ccr_after_adc", ccr, 2'b00);
        next_cycle();
        set_instr(OP_NAND, COND_ALWAYS, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'd0,
                  1'b0, 3'd5, 1'b1);
        issue(mk(16'h0000, 3'd5, 1'b1, 2'b10), "nand_ones");
        @(negedge clk);
        chk("ccr_after_nand", ccr, 2'b10);
        next_cycle();

        // Zero-conditional skip: result still flows, no write, CCR untouched
        set_instr(OP_ADD, COND_ALWAYS, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'd1, 16'd1, 16'd0, 1'b0,
                  3'd1, 1'b1);
        issue(mk(16'd2, 3'd1, 1'b1, 2'b00), "add_clear_ccr");
        set_instr(OP_ADD, COND_ZERO, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'd0,
                  1'b0, 3'd2, 1'b1);
        issue(mk(16'h0000, 3'd2, 1'b0, 2'b11), "adz_skip");
        @(negedge clk);
        chk("ccr_after_skip", ccr, 2'b00);
        next_cycle();

        // Late CCR write bypasses into the condition; the executing instruction wins the CCR
        bus.ccr_wr_en  = 1'b1;
        bus.ccr_wr_val = 2'b01;
        set_instr(OP_ADD, COND_CARRY, 1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 16'd2, 16'd3, 16'd0, 1'b0,
                  3'd3, 1'b1);
        issue(mk(16'd5, 3'd3, 1'b1, 2'b00), "adc_late_bypass");
        bus.ccr_wr_en = 1'b0;
        @(negedge clk);
        chk("ccr_exec_wins", ccr, 2'b00);
        next_cycle();
        bus.ccr_wr_en  = 1'b1;
        bus.ccr_wr_val = 2'b10;
        next_cycle();
        bus.ccr_wr_en = 1'b0;
        @(negedge clk);
        chk("ccr_late_write", ccr, 2'b10);
        next_cycle();

        // Load-use stall on bypass entry 1, released when the load data arrives
        set_fwd(1, 1'b1, 3'd3, 16'h0000, 1'b1);
        set_instr(OP_ADD, COND_ALWAYS, 1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 16'h1111, 16'h0, 16'h0010,
                  1'b1, 3'd6, 1'b1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("load_use_ready_0", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("load_use_ready_1", bus.in_ready, 0);
        chk("stall_cnt_1", stall_cnt, 1);
        next_cycle();
        set_fwd(1, 1'b1, 3'd3, 16'h0042, 1'b0);
        @(negedge clk);
        chk("stall_cnt_2", stall_cnt, 2);
        chk("load_use_release", bus.in_ready, 1);
        @(posedge clk);
        sb.push_back(mk(16'h0052, 3'd6, 1'b1, 2'b00));
        #1;
        bus.in_valid = 1'b0;
        set_fwd(1, 1'b0, 3'd0, 16'h0, 1'b0);

        // Bypass priority: entry 0 beats entry 2, own register beats both
        set_fwd(0, 1'b1, 3'd4, 16'h000A, 1'b0);
        set_fwd(2, 1'b1, 3'd4, 16'h000B, 1'b0);
        set_instr(OP_ADD, COND_ALWAYS, 1'b0, 3'd4, 3'd0, 1'b1, 1'b0, 16'h00FF, 16'h0, 16'h0, 1'b1,
                  3'd5, 1'b1);
        issue(mk(16'h000A, 3'd5, 1'b1, 2'b00), "prio_fwd0");
        set_instr(OP_PASS, COND_ALWAYS, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h000C,
                  1'b1, 3'd4, 1'b1);
        issue(mk(16'h000C, 3'd4, 1'b1, 2'b00), "write_r4");
        set_instr(OP_PASS, COND_ALWAYS, 1'b0, 3'd0, 3'd4, 1'b0, 1'b1, 16'h0, 16'h00EE, 16'h0,
                  1'b0, 3'd6, 1'b1);
        issue(mk(16'h000C, 3'd6, 1'b1, 2'b00), "prio_own");
        set_fwd(0, 1'b0, 3'd0, 16'h0, 1'b0);
        set_fwd(2, 1'b0, 3'd0, 16'h0, 1'b0);
        repeat (2) next_cycle();

        // Backpressure: output holds and the stage refuses new work
        bus.out_ready = 1'b0;
        set_instr(OP_ADD, COND_ALWAYS, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h0001, 16'h0,
                  1'b0, 3'd1, 1'b1);
        issue(mk(16'h1235, 3'd1, 1'b1, 2'b00), "bp_first");
        set_instr(OP_PASS, COND_ALWAYS, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0077,
                  1'b1, 3'd2, 1'b1);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_hold_result", bus.out_result, 16'h1235);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        sb.push_back(mk(16'h0077, 3'd2, 1'b1, 2'b00));
        #1;
        bus.in_valid = 1'b0;

        // Flush kills the offered instruction; the older late CCR write still lands
        flush          = 1'b1;
        bus.ccr_wr_en  = 1'b1;
        bus.ccr_wr_val = 2'b01;
        set_instr(OP_ADD, COND_ALWAYS, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0,
                  1'b0, 3'd3, 1'b1);
        bus.in_valid = 1'b1;
        next_cycle();
        flush         = 1'b0;
        bus.ccr_wr_en = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_ccr", ccr, 2'b01);
        chk("stall_cnt_no_bp", stall_cnt, 2);
        next_cycle();

        // Reset in the middle of a flag-hazard stall with a held result
        bus.out_ready = 1'b0;
        set_instr(OP_PASS, COND_ALWAYS, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555,
                  1'b1, 3'd7, 1'b1);
        bus.in_valid = 1'b1;
        next_cycle();
        bus.flag_pending = 1'b1;
        set_instr(OP_ADD, COND_CARRY, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd1, 16'd1, 16'h0, 1'b0,
                  3'd1, 1'b1);
        @(negedge clk);
        chk("flag_hazard_ready", bus.in_ready, 0);
        chk("held_valid", bus.out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_cnt_flag", stall_cnt, 3);
        next_cycle();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_result", bus.out_result, 0);
        chk("mid_rst_out_dest", bus.out_dest, 0);
        chk("mid_rst_out_wr_en", bus.out_wr_en, 0);
        chk("mid_rst_out_flags", bus.out_flags, 0);
        chk("mid_rst_ccr", ccr, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        next_cycle();
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.flag_pending = 1'b0;
        bus.out_ready    = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
